weight_row_mac: RTL

Sequential multiply-accumulate stage that consumes one 28-entry weight row from a weight block RAM and an activation stream, producing one Q8.8 neuron pre-activation per START. Sits directly downstream of a per-neuron weight BRAM: drives its address/enable and reads its negedge-registered data output. Output feeds the layer's activation/result collector through a valid/ready handshake.

---
 rtl/weight_row_mac.sv | 124 ++++++++++++
 1 files changed

// File: rtl/weight_row_mac.sv
// rtl/weight_row_mac.sv - Q8.8 weight-row multiply-accumulate stage fed by a negedge-registered weight BRAM
// Optional feature: define WEIGHT_ROW_MAC_RELU_EN to clamp negative results to zero.
module weight_row_mac #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int ACCW  = 40
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [DW-1:0] BIAS,
    input  logic [DW-1:0] X_DATA,
    input  logic          X_VALID,
    output logic          X_READY,
    output logic [AW-1:0] W_ADDR,
    output logic          W_EN,
    input  logic [DW-1:0] W_DO,
    output logic [DW-1:0] Y_DATA,
    output logic          Y_VALID,
    input  logic          Y_READY,
    output logic          BUSY
);

    typedef enum logic [1:0] {IDLE, FETCH, RUN, OUT} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t                 state;
    logic [AW-1:0]          idx;
    logic [DW-1:0]          bias_q;
    logic                   out_pend;
    logic signed [ACCW-1:0] acc;

    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] acc_next;
    logic signed [ACCW-1:0] bias_ext;
    logic signed [ACCW-1:0] biased;
    logic signed [ACCW-1:0] shifted;
    logic [DW-1:0]          sat;

    assign prod     = $signed(X_DATA) * $signed(W_DO);
    assign acc_next = acc + $signed({{(ACCW-2*DW){prod[2*DW-1]}}, prod});
    assign bias_ext = $signed({{(ACCW-DW){bias_q[DW-1]}}, bias_q});
    assign biased   = acc + (bias_ext <<< FRAC);
    assign shifted  = biased >>> FRAC;

    // Saturate when the bits above the Q8.8 sign bit are not a pure sign extension.
    always_comb begin
        sat = shifted[DW-1:0];
        if (shifted[ACCW-1:DW-1] != '0 && shifted[ACCW-1:DW-1] != '1) begin
            sat = shifted[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
`ifdef WEIGHT_ROW_MAC_RELU_EN
        if (sat[DW-1]) begin
            sat = '0;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            idx      <= '0;
            acc      <= '0;
            bias_q   <= '0;
            out_pend <= 1'b0;
            X_READY  <= 1'b0;
            W_ADDR   <= '0;
            W_EN     <= 1'b0;
            Y_DATA   <= '0;
            Y_VALID  <= 1'b0;
            BUSY     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        bias_q <= BIAS;
                        idx    <= '0;
                        acc    <= '0;
                        W_ADDR <= '0;
                        W_EN   <= 1'b1;
                        BUSY   <= 1'b1;
                        state  <= FETCH;
                    end
                end
                // BRAM samples W_ADDR on the negedge inside this cycle.
                FETCH: begin
                    X_READY <= 1'b1;
                    state   <= RUN;
                end
                RUN: begin
                    if (X_VALID && X_READY) begin
                        acc     <= acc_next;
                        X_READY <= 1'b0;
                        if (idx == LAST) begin
                            W_EN     <= 1'b0;
                            out_pend <= 1'b1;
                            state    <= OUT;
                        end else begin
                            idx    <= idx + 1'b1;
                            W_ADDR <= idx + 1'b1;
                            state  <= FETCH;
                        end
                    end
                end
                OUT: begin
                    if (out_pend) begin
                        Y_DATA   <= sat;
                        Y_VALID  <= 1'b1;
                        out_pend <= 1'b0;
                    end else if (Y_READY) begin
                        Y_VALID <= 1'b0;
                        BUSY    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
